cg_priority_decoder: RTL and testbench

//   Streaming index-to-one-hot decoder: the inverse of the priority encoder. Accepts an
//   (index, enable) pair per beat over valid/ready and emits a BITS_WIDTH one-hot vector

---
 rtl/cg_priority_decoder.sv | 94 +++++++++
 tb/tb_cg_priority_decoder.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/cg_priority_decoder.sv
// Streaming index-to-one-hot decoder with a 2-entry (main + skid) registered buffer.
// Optional macro CG_PRIORITY_DECODER_ERR_EN adds o_out_err for enabled out-of-range indices.
module cg_priority_decoder #(
    parameter  int BITS_WIDTH  = 16,
    localparam int INDEX_WIDTH = $clog2(BITS_WIDTH)
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic                   i_in_valid,
    output logic                   o_in_ready,
    input  logic [INDEX_WIDTH-1:0] i_in_index,
    input  logic                   i_in_en,
    output logic                   o_out_valid,
    input  logic                   i_out_ready,
`ifdef CG_PRIORITY_DECODER_ERR_EN
    output logic                   o_out_err,
`endif
    output logic [BITS_WIDTH-1:0]  o_out_bits
);

    logic                  r_main_valid;
    logic                  r_skid_valid;
    logic [BITS_WIDTH-1:0] r_main_bits;
    logic [BITS_WIDTH-1:0] r_skid_bits;
    logic [BITS_WIDTH-1:0] w_dec_bits;
    logic                  w_in_fire;
    logic                  w_out_fire;
    logic                  w_main_load;

    assign o_in_ready  = !r_skid_valid;
    assign o_out_valid = r_main_valid;
    assign o_out_bits  = r_main_bits;

    assign w_in_fire   = i_in_valid && !r_skid_valid;
    assign w_out_fire  = r_main_valid && i_out_ready;
    assign w_main_load = !r_main_valid || w_out_fire;

    // Indices at or beyond BITS_WIDTH match no bit, so they decode to zero.
    always_comb begin
        w_dec_bits = '0;
        for (int unsigned i = 0; i < BITS_WIDTH; i++) begin
            if (i_in_en && (32'(i_in_index) == i)) begin
                w_dec_bits[i] = 1'b1;
            end
        end
    end

`ifdef CG_PRIORITY_DECODER_ERR_EN
    logic r_main_err;
    logic r_skid_err;
    logic w_dec_err;

    assign w_dec_err = i_in_en && (32'(i_in_index) >= 32'(BITS_WIDTH));
    assign o_out_err = r_main_err;
`endif

    // A full skid implies o_in_ready=0, so the refill from skid never races a new beat.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main_bits  <= '0;
            r_skid_bits  <= '0;
`ifdef CG_PRIORITY_DECODER_ERR_EN
            r_main_err   <= 1'b0;
            r_skid_err   <= 1'b0;
`endif
        end else if (w_main_load) begin
            if (r_skid_valid) begin
                r_main_valid <= 1'b1;
                r_main_bits  <= r_skid_bits;
                r_skid_valid <= 1'b0;
`ifdef CG_PRIORITY_DECODER_ERR_EN
                r_main_err   <= r_skid_err;
`endif
            end else begin
                r_main_valid <= w_in_fire;
                if (w_in_fire) begin
                    r_main_bits <= w_dec_bits;
`ifdef CG_PRIORITY_DECODER_ERR_EN
                    r_main_err  <= w_dec_err;
`endif
                end
            end
        end else if (w_in_fire) begin
            r_skid_valid <= 1'b1;
            r_skid_bits  <= w_dec_bits;
`ifdef CG_PRIORITY_DECODER_ERR_EN
            r_skid_err   <= w_dec_err;
`endif
        end
    end

endmodule

// File: tb/tb_cg_priority_decoder.sv
// Bench for cg_priority_decoder: a 16-bit and a 10-bit instance, directed tables plus
// random valid/ready traffic checked against a queue-based reference model.
module tb_cg_priority_decoder;

    typedef struct {
        logic [3:0]  idx;
        logic        en;
        logic [15:0] exp_bits;
    } vec_t;

    typedef struct {
        logic [15:0] bits;
        logic        err;
    } beat_t;

    logic        clk;
    logic        rst_n;

    logic        in_valid_a, in_ready_a, en_a, out_valid_a, out_ready_a;
    logic [3:0]  idx_a;
    logic [15:0] bits_a;
    logic        in_valid_b, in_ready_b, en_b, out_valid_b, out_ready_b;
    logic [3:0]  idx_b;
    logic [9:0]  bits_b;
`ifdef CG_PRIORITY_DECODER_ERR_EN
    logic        err_a, err_b;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    cg_priority_decoder #(.BITS_WIDTH(16)) u_dut16 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid_a),
        .o_in_ready  (in_ready_a),
        .i_in_index  (idx_a),
        .i_in_en     (en_a),
        .o_out_valid (out_valid_a),
        .i_out_ready (out_ready_a),
`ifdef CG_PRIORITY_DECODER_ERR_EN
        .o_out_err   (err_a),
`endif
        .o_out_bits  (bits_a)
    );

    cg_priority_decoder #(.BITS_WIDTH(10)) u_dut10 (
        .i_clk       (clk),
        .i_rst_n     (rst_n),
        .i_in_valid  (in_valid_b),
        .o_in_ready  (in_ready_b),
        .i_in_index  (idx_b),
        .i_in_en     (en_b),
        .o_out_valid (out_valid_b),
        .i_out_ready (out_ready_b),
`ifdef CG_PRIORITY_DECODER_ERR_EN
        .o_out_err   (err_b),
`endif
        .o_out_bits  (bits_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic beat_t ref_decode(input int idx, input bit en, input int width);
        beat_t b;
        b.bits = (en && idx < width) ? 16'(1 << idx) : 16'h0;
        b.err  = en && idx >= width;
        return b;
    endfunction

    vec_t  tbl[4];
    beat_t qa[$];
    beat_t qb[$];

    initial begin
        tbl[0] = '{idx: 4'd0,  en: 1'b1, exp_bits: 16'h0001};
        tbl[1] = '{idx: 4'd5,  en: 1'b1, exp_bits: 16'h0020};
        tbl[2] = '{idx: 4'd15, en: 1'b1, exp_bits: 16'h8000};
        tbl[3] = '{idx: 4'd7,  en: 1'b0, exp_bits: 16'h0000};

        rst_n = 1'b0;
        in_valid_a = 0; idx_a = 0; en_a = 0; out_ready_a = 1;
        in_valid_b = 0; idx_b = 0; en_b = 0; out_ready_b = 1;

        // Reset state
        #12;
        check("rst_valid16", 32'(out_valid_a), 0);
        check("rst_bits16",  32'(bits_a), 0);
        check("rst_ready16", 32'(in_ready_a), 1);
        check("rst_valid10", 32'(out_valid_b), 0);
        check("rst_ready10", 32'(in_ready_b), 1);
`ifdef CG_PRIORITY_DECODER_ERR_EN
        check("rst_err16", 32'(err_a), 0);
`endif
        rst_n = 1'b1;
        step();

        // Back-to-back beats, 1-cycle latency, including an en=0 beat
        for (int i = 0; i < 4; i++) begin
            in_valid_a = 1; idx_a = tbl[i].idx; en_a = tbl[i].en;
            step();
            check($sformatf("tbl%0d_valid", i), 32'(out_valid_a), 1);
            check($sformatf("tbl%0d_bits", i),  32'(bits_a), 32'(tbl[i].exp_bits));
            check($sformatf("tbl%0d_ready", i), 32'(in_ready_a), 1);
        end
        in_valid_a = 0;
        step();
        check("drain_valid", 32'(out_valid_a), 0);

        // Backpressure: fill main and skid, then release
        out_ready_a = 0;
        in_valid_a = 1; idx_a = 1; en_a = 1;
        step();
        check("bp1_bits",  32'(bits_a), 32'h0002);
        check("bp1_ready", 32'(in_ready_a), 1);
        idx_a = 2;
        step();
        check("bp2_bits",  32'(bits_a), 32'h0002);
        check("bp2_ready", 32'(in_ready_a), 0);
        in_valid_a = 0;
        step();
        check("bp3_hold",  32'(bits_a), 32'h0002);
        check("bp3_valid", 32'(out_valid_a), 1);
        out_ready_a = 1;
        step();
        check("bp4_bits",  32'(bits_a), 32'h0004);
        check("bp4_ready", 32'(in_ready_a), 1);
        in_valid_a = 1; idx_a = 3;
        step();
        check("bp5_bits",  32'(bits_a), 32'h0008);
        in_valid_a = 0;
        step();
        check("bp6_valid", 32'(out_valid_a), 0);

        // Non-power-of-2 width: out-of-range index decodes to zero
        in_valid_b = 1; idx_b = 12; en_b = 1;
        step();
        check("w10_oor_valid", 32'(out_valid_b), 1);
        check("w10_oor_bits",  32'(bits_b), 0);
`ifdef CG_PRIORITY_DECODER_ERR_EN
        check("w10_oor_err", 32'(err_b), 1);
`endif
        idx_b = 9;
        step();
        check("w10_top_bits", 32'(bits_b), 32'h200);
`ifdef CG_PRIORITY_DECODER_ERR_EN
        check("w10_top_err", 32'(err_b), 0);
`endif
        idx_b = 10;
        step();
        check("w10_edge_bits", 32'(bits_b), 0);
        in_valid_b = 0;
        step();

        // Asynchronous reset with the skid full
        out_ready_a = 0;
        in_valid_a = 1; idx_a = 6;
        step();
        idx_a = 8;
        step();
        check("skid_full_ready", 32'(in_ready_a), 0);
        in_valid_a = 0;
        #3 rst_n = 1'b0;
        #1;
        check("arst_valid", 32'(out_valid_a), 0);
        check("arst_bits",  32'(bits_a), 0);
        check("arst_ready", 32'(in_ready_a), 1);
        #2 rst_n = 1'b1;
        out_ready_a = 1;
        step();
        check("post_rst_valid", 32'(out_valid_a), 0);
        in_valid_a = 1; idx_a = 4; en_a = 1;
        step();
        check("post_rst_bits", 32'(bits_a), 32'h0010);
        in_valid_a = 0;
        step();

        // Random traffic on both instances against the queue model
        begin
            int beats = 0;
            int cycles = 0;
            qa.delete();
            qb.delete();
            while (beats < 10000 && cycles < 60000) begin
                bit fire_in, fire_out;
                check("rnd_valid16", 32'(out_valid_a), 32'(qa.size() > 0));
                check("rnd_ready16", 32'(in_ready_a),  32'(qa.size() < 2));
                if (qa.size() > 0) check("rnd_bits16", 32'(bits_a), 32'(qa[0].bits));
                check("rnd_valid10", 32'(out_valid_b), 32'(qb.size() > 0));
                check("rnd_ready10", 32'(in_ready_b),  32'(qb.size() < 2));
                if (qb.size() > 0) check("rnd_bits10", 32'(bits_b), 32'(qb[0].bits));
`ifdef CG_PRIORITY_DECODER_ERR_EN
                if (qa.size() > 0) check("rnd_err16", 32'(err_a), 32'(qa[0].err));
                if (qb.size() > 0) check("rnd_err10", 32'(err_b), 32'(qb[0].err));
`endif
                in_valid_a  = ($urandom_range(0, 3) != 0);
                idx_a       = 4'($urandom_range(0, 15));
                en_a        = ($urandom_range(0, 7) != 0);
                out_ready_a = ($urandom_range(0, 3) != 0);
                in_valid_b  = ($urandom_range(0, 3) != 0);
                idx_b       = 4'($urandom_range(0, 15));
                en_b        = ($urandom_range(0, 7) != 0);
                out_ready_b = ($urandom_range(0, 3) != 0);

                fire_out = (qa.size() > 0) && out_ready_a;
                fire_in  = in_valid_a && (qa.size() < 2);
                if (fire_out) void'(qa.pop_front());
                if (fire_in) begin
                    qa.push_back(ref_decode(int'(idx_a), en_a, 16));
                    beats++;
                end
                fire_out = (qb.size() > 0) && out_ready_b;
                fire_in  = in_valid_b && (qb.size() < 2);
                if (fire_out) void'(qb.pop_front());
                if (fire_in) qb.push_back(ref_decode(int'(idx_b), en_b, 10));

                step();
                cycles++;
            end
            check("rnd_beat_budget", 32'(beats >= 10000), 1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
